// File: rtl/smod_seq.sv
// smod_seq: multi-cycle signed divide/modulo unit.
// Operands are reduced to unsigned magnitudes and divided by a restoring
// divider that produces one quotient bit per cycle, MSB first. Signs are
// applied in a final fix-up cycle: the quotient truncates toward zero and
// the remainder follows the sign of the dividend. A zero divisor skips the
// iteration and returns quot = -1, rem = a.
module smod_seq #(
   parameter int DATAWIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] quot,
   output logic [DATAWIDTH-1:0] rem,
   output logic                 rem_zero,
   output logic                 div_by_zero
);

   localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Two's-complement negate when neg is set, pass through otherwise.
   function automatic logic [DATAWIDTH-1:0] cond_neg(
      input logic [DATAWIDTH-1:0] v,
      input logic                 neg
   );
      logic [DATAWIDTH-1:0] res;
      if (neg) begin
         res = ~v + {{(DATAWIDTH-1){1'b0}}, 1'b1};
      end else begin
         res = v;
      end
      return res;
   endfunction

   // Unsigned magnitude of a signed value; |-2^(W-1)| = 2^(W-1) is exact.
   function automatic logic [DATAWIDTH-1:0] abs_val(
      input logic [DATAWIDTH-1:0] v
   );
      return cond_neg(v, v[DATAWIDTH-1]);
   endfunction

   // Sequencer and datapath state
   state_t               state_r, state_s;
   logic [CW-1:0]        cnt_r, cnt_s;
   logic [DATAWIDTH-1:0] dvd_r, dvd_s;     // |a|, shifted out MSB first
   logic [DATAWIDTH-1:0] dvs_r, dvs_s;     // |b|
   logic [DATAWIDTH-1:0] prem_r, prem_s;   // partial remainder (< |b|)
   logic [DATAWIDTH-1:0] quo_r, quo_s;     // unsigned quotient bits
   logic                 sa_r, sa_s;       // sign of dividend
   logic                 sq_r, sq_s;       // sign of quotient
   logic                 dbz_r, dbz_s;     // captured divisor was zero

   // Output registers
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
   logic [DATAWIDTH-1:0] quot_r, quot_s;
   logic [DATAWIDTH-1:0] rem_r, rem_s;
   logic                 rz_r, rz_s;
   logic                 dbzo_r, dbzo_s;

   // Restoring step operands (partial remainder widened to W+1 bits)
   logic [DATAWIDTH:0]   shifted_s;
   logic [DATAWIDTH-1:0] trial_s;
   logic                 take_s;

   assign busy        = busy_r;
   assign done        = done_r;
   assign quot        = quot_r;
   assign rem         = rem_r;
   assign rem_zero    = rz_r;
   assign div_by_zero = dbzo_r;

   // One restoring step: shift in next dividend bit, subtract |b| if it fits.
   always_comb begin
      shifted_s = {prem_r, dvd_r[DATAWIDTH-1]};
      take_s    = (shifted_s >= {1'b0, dvs_r});
      // When take_s is set the true difference is below |b|, so W bits hold it.
      trial_s   = shifted_s[DATAWIDTH-1:0] - dvs_r;
   end

   // Next-state and next-output logic for IDLE -> CALC -> FIX sequencing.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      dvd_s   = dvd_r;
      dvs_s   = dvs_r;
      prem_s  = prem_r;
      quo_s   = quo_r;
      sa_s    = sa_r;
      sq_s    = sq_r;
      dbz_s   = dbz_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      quot_s  = quot_r;
      rem_s   = rem_r;
      rz_s    = rz_r;
      dbzo_s  = dbzo_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               dvd_s  = abs_val(a);
               dvs_s  = abs_val(b);
               sa_s   = a[DATAWIDTH-1];
               sq_s   = a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
               prem_s = {DATAWIDTH{1'b0}};
               quo_s  = {DATAWIDTH{1'b0}};
               busy_s = 1'b1;
               if (b == {DATAWIDTH{1'b0}}) begin
                  dbz_s   = 1'b1;
                  cnt_s   = {CW{1'b0}};
                  state_s = ST_FIX;
               end else begin
                  dbz_s   = 1'b0;
                  cnt_s   = CW'(DATAWIDTH - 1);
                  state_s = ST_CALC;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_CALC: begin
            if (take_s) begin
               prem_s = trial_s;
            end else begin
               prem_s = shifted_s[DATAWIDTH-1:0];
            end
            quo_s = {quo_r[DATAWIDTH-2:0], take_s};
            dvd_s = {dvd_r[DATAWIDTH-2:0], 1'b0};
            if (cnt_r == {CW{1'b0}}) begin
               state_s = ST_FIX;
            end else begin
               cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end

         ST_FIX: begin
            if (dbz_r) begin
               // dvd_r still holds |a|; re-signing it restores a exactly.
               quot_s = {DATAWIDTH{1'b1}};
               rem_s  = cond_neg(dvd_r, sa_r);
            end else begin
               quot_s = cond_neg(quo_r, sq_r);
               rem_s  = cond_neg(prem_r, sa_r);
            end
            rz_s    = (rem_s == {DATAWIDTH{1'b0}});
            dbzo_s  = dbz_r;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         dvd_r   <= {DATAWIDTH{1'b0}};
         dvs_r   <= {DATAWIDTH{1'b0}};
         prem_r  <= {DATAWIDTH{1'b0}};
         quo_r   <= {DATAWIDTH{1'b0}};
         sa_r    <= 1'b0;
         sq_r    <= 1'b0;
         dbz_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         quot_r  <= {DATAWIDTH{1'b0}};
         rem_r   <= {DATAWIDTH{1'b0}};
         rz_r    <= 1'b0;
         dbzo_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         dvd_r   <= dvd_s;
         dvs_r   <= dvs_s;
         prem_r  <= prem_s;
         quo_r   <= quo_s;
         sa_r    <= sa_s;
         sq_r    <= sq_s;
         dbz_r   <= dbz_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         quot_r  <= quot_s;
         rem_r   <= rem_s;
         rz_r    <= rz_s;
         dbzo_r  <= dbzo_s;
      end
   end

endmodule
